// File: rtl/apb_pkg.sv
// Shared types and default sizing for the round-robin APB master.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;

   localparam int unsigned APB_AW      = 32;
   localparam int unsigned APB_DW      = 32;
   localparam int unsigned APB_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request strictly after last_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   last_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_req_o
);

   logic          found;
   logic [IW-1:0] cidx;

   assign any_req_o = |req_i;

   always_comb begin
      found = 1'b0;
      idx_o = '0;
      cidx  = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cidx = IW'((32'(last_i) + i) % NREQ);
         if (!found && req_i[cidx]) begin
            found = 1'b1;
            idx_o = cidx;
         end
      end
      grant_o = found ? (NREQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/apb_rr_mst.sv
// APB master shared by NREQ requesters under round-robin arbitration,
// with an ACCESS wait-state timeout that aborts hung transfers.
module apb_rr_mst
   import apb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned AW      = APB_AW,
   parameter int unsigned DW      = APB_DW,
   parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_valid,
   input  logic [NREQ-1:0]  req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]  req_ack,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [DW-1:0]    rsp_rdata,
   output logic             rsp_err,
   output logic             psel,
   output logic             penable,
   output logic             pwrite,
   output logic [AW-1:0]    paddr,
   output logic [DW-1:0]    pwdata,
   input  logic             pready,
   input  logic [DW-1:0]    prdata,
   input  logic             pslverr
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(TIMEOUT);

   apb_state_e       state_q, state_d;
   logic [IW-1:0]    last_q, last_d;
   logic             pwrite_q, pwrite_d;
   logic [AW-1:0]    paddr_q, paddr_d;
   logic [DW-1:0]    pwdata_q, pwdata_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [NREQ-1:0]  rspv_q, rspv_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [NREQ-1:0]  win_oh;
   logic [IW-1:0]    win_idx;
   logic             any_req;
   logic             take;
   logic [NREQ-1:0]  gnt_oh;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req_i     (req_valid),
      .last_i    (last_q),
      .grant_o   (win_oh),
      .idx_o     (win_idx),
      .any_req_o (any_req)
   );

   // The RR pointer is also the index of the requester currently on the bus.
   assign gnt_oh = NREQ'(1) << last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= IW'(NREQ - 1);
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         ack_q    <= '0;
         rspv_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         ack_q    <= ack_d;
         rspv_q   <= rspv_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      ack_d    = '0;
      rspv_d   = '0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      take     = 1'b0;

      case (state_q)
         IDLE: begin
            take = any_req;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            if (pready) begin
               rspv_d = gnt_oh;
               err_d  = pslverr;
               if (!pwrite_q) begin
                  rdata_d = prdata;
               end
               if (any_req) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rspv_d  = gnt_oh;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (take) begin
         state_d  = SETUP;
         last_d   = win_idx;
         pwrite_d = req_write[win_idx];
         paddr_d  = req_addr[win_idx*AW +: AW];
         pwdata_d = req_wdata[win_idx*DW +: DW];
         ack_d    = win_oh;
      end
   end

   assign psel      = (state_q != IDLE);
   assign penable   = (state_q == ACCESS);
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign req_ack   = ack_q;
   assign rsp_valid = rspv_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_rr_mst.sv
// Scoreboard bench for apb_rr_mst: directed requests, queued expected acks/responses.
module tb_apb_rr_mst;

   localparam int NREQ    = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   req_ack;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [AW-1:0]     paddr;
   logic [DW-1:0]     pwdata;
   logic              pready;
   logic [DW-1:0]     prdata;
   logic              pslverr;

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   int   ackq[$];
   rsp_t rspq[$];
   int   checks    = 0;
   int   failures  = 0;
   int   pen_total = 0;
   int   slave_wait = 0;
   int   wcnt      = 0;
   bit   rd_auto   = 1'b0;

   apb_rr_mst #(
      .NREQ    (NREQ),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ack   (req_ack),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pready    (pready),
      .prdata    (prdata),
      .pslverr   (pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: protocol invariants plus scoreboard pops on ack/response pulses.
   initial begin : mon
      logic [31:0] cap_addr;
      logic [31:0] cap_wdata;
      logic        cap_wr;
      int          e;
      rsp_t        r;
      cap_addr  = '0;
      cap_wdata = '0;
      cap_wr    = 1'b0;
      forever begin
         @(negedge clk);
         if (penable) begin
            pen_total++;
            chk("inv_penable_psel", 32'(psel), 1);
            chk("stable_paddr", paddr, cap_addr);
            chk("stable_pwdata", pwdata, cap_wdata);
            chk("stable_pwrite", 32'(pwrite), 32'(cap_wr));
         end else if (psel) begin
            cap_addr  = paddr;
            cap_wdata = pwdata;
            cap_wr    = pwrite;
         end
         if (req_ack != '0) begin
            if (ackq.size() == 0) begin
               chk("ack_unexpected", 32'(req_ack), 0);
            end else begin
               e = ackq.pop_front();
               chk("ack_grant", 32'(req_ack), 32'(1) << e);
            end
         end
         if (rsp_valid != '0) begin
            if (rspq.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
               r = rspq.pop_front();
               chk("rsp_valid", 32'(rsp_valid), 32'(1) << r.idx);
               chk("rsp_rdata", rsp_rdata, r.rdata);
               chk("rsp_err", 32'(rsp_err), 32'(r.err));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // One clock step; requesters drop req_valid after ack, slave answers in ACCESS.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ack[i]) req_valid[i] = 1'b0;
      end
      if (psel && penable) begin
         if (wcnt < slave_wait) begin
            pready = 1'b0;
            wcnt++;
         end else begin
            pready = 1'b1;
         end
         if (rd_auto) prdata = paddr ^ 32'hFFFF_0000;
      end else begin
         pready = 1'b0;
         wcnt   = 0;
      end
   endtask

   task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      req_valid[i]           = 1'b1;
      req_write[i]           = w;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
   endtask

   task automatic exp_rsp(input int i, input logic [31:0] d, input logic e);
      rsp_t r;
      r.idx   = i;
      r.rdata = d;
      r.err   = e;
      rspq.push_back(r);
   endtask

   // Counts consecutive psel-high cycles of one bus tenure.
   task automatic burst(input string name, input int exp_len);
      int n;
      int t;
      n = 0;
      t = 0;
      while (!psel && t < 50) begin
         cycle();
         t++;
      end
      while (psel && n < 100) begin
         n++;
         cycle();
      end
      chk(name, n, exp_len);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((ackq.size() != 0 || rspq.size() != 0) && t < 50) begin
         cycle();
         t++;
      end
      cycle();
      chk("drain_ack", ackq.size(), 0);
      chk("drain_rsp", rspq.size(), 0);
   endtask

   initial begin
      int p0;
      int t;
      rst       = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      pready    = 1'b0;
      prdata    = '0;
      pslverr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_psel_penable", {psel, penable}, 0);
      chk("reset_pwrite", 32'(pwrite), 0);
      chk("reset_paddr", paddr, 0);
      chk("reset_pwdata", pwdata, 0);
      chk("reset_rdata_err", {rsp_rdata[30:0], rsp_err}, 0);
      chk("reset_ack_rsp", {req_ack, rsp_valid}, 0);
      rst = 1'b0;
      cycle();

      // All four at once from reset: 0,1,2,3 back-to-back.
      rd_auto    = 1'b1;
      slave_wait = 0;
      p0 = pen_total;
      for (int i = 0; i < 4; i++) begin
         ackq.push_back(i);
         exp_rsp(i, 32'hFFFF_0100 + 32'(4 * i), 1'b0);
         issue(i, 1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0);
      end
      burst("rr4_psel_cycles", 8);
      drain();
      chk("rr4_penable_cycles", pen_total - p0, 4);

      // Pointer now at 3: req1 and req3 -> 1 then 3.
      ackq.push_back(1);
      ackq.push_back(3);
      exp_rsp(1, 32'hFFFF_0200, 1'b0);
      exp_rsp(3, 32'hFFFF_0300, 1'b0);
      issue(1, 1'b0, 32'h0000_0200, 32'h0);
      issue(3, 1'b0, 32'h0000_0300, 32'h0);
      burst("rr2_psel_cycles", 4);
      drain();

      // Single read, zero wait states.
      rd_auto = 1'b0;
      prdata  = 32'hDEAD_CAFE;
      p0 = pen_total;
      ackq.push_back(0);
      exp_rsp(0, 32'hDEAD_CAFE, 1'b0);
      issue(0, 1'b0, 32'h0000_1000, 32'h0);
      burst("single_psel_cycles", 2);
      drain();
      chk("single_penable_cycles", pen_total - p0, 1);

      // Write with 3 wait states; rdata must hold, late field changes ignored.
      prdata     = 32'h5555_5555;
      slave_wait = 3;
      p0 = pen_total;
      ackq.push_back(1);
      exp_rsp(1, 32'hDEAD_CAFE, 1'b0);
      issue(1, 1'b1, 32'h0000_0020, 32'h1234_5678);
      cycle();
      chk("wr_setup_paddr", paddr, 32'h0000_0020);
      chk("wr_setup_pwdata", pwdata, 32'h1234_5678);
      chk("wr_setup_pwrite", 32'(pwrite), 1);
      req_addr[1*AW +: AW]  = 32'hFFFF_FFFF;
      req_wdata[1*DW +: DW] = 32'h0BAD_0BAD;
      burst("wr_psel_cycles", 5);
      drain();
      chk("wr_penable_cycles", pen_total - p0, 4);

      // Hung slave: TIMEOUT ACCESS cycles then error response with zero data.
      slave_wait = 1000;
      prdata     = 32'h0000_0077;
      p0 = pen_total;
      ackq.push_back(2);
      exp_rsp(2, 32'h0, 1'b1);
      issue(2, 1'b0, 32'h0000_0040, 32'h0);
      burst("to_psel_cycles", TIMEOUT + 1);
      drain();
      chk("to_penable_cycles", pen_total - p0, TIMEOUT);
      chk("to_idle_psel", 32'(psel), 0);

      // Slave error with data.
      slave_wait = 0;
      prdata     = 32'h0000_00AA;
      pslverr    = 1'b1;
      ackq.push_back(0);
      exp_rsp(0, 32'h0000_00AA, 1'b1);
      issue(0, 1'b0, 32'h0000_0030, 32'h0);
      burst("err_psel_cycles", 2);
      drain();
      pslverr = 1'b0;

      // Reset during a wait state: no response, everything cleared, pointer reset.
      slave_wait = 1000;
      ackq.push_back(2);
      issue(2, 1'b0, 32'h0000_0050, 32'h0);
      t = 0;
      while (!penable && t < 20) begin
         cycle();
         t++;
      end
      chk("rst_reached_access", 32'(penable), 1);
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      chk("rst_mid_psel_penable", {psel, penable}, 0);
      chk("rst_mid_paddr", paddr, 0);
      chk("rst_mid_pwdata_pwrite", {pwdata[30:0], pwrite}, 0);
      chk("rst_mid_rdata", rsp_rdata, 0);
      chk("rst_mid_err", 32'(rsp_err), 0);
      chk("rst_mid_ack_rsp", {req_ack, rsp_valid}, 0);
      rst = 1'b0;
      repeat (3) cycle();
      drain();

      rd_auto    = 1'b1;
      slave_wait = 0;
      ackq.push_back(2);
      ackq.push_back(3);
      exp_rsp(2, 32'hFFFF_0400, 1'b0);
      exp_rsp(3, 32'hFFFF_0500, 1'b0);
      issue(2, 1'b0, 32'h0000_0400, 32'h0);
      issue(3, 1'b0, 32'h0000_0500, 32'h0);
      burst("post_rst_psel_cycles", 4);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_rr_mst.md
Name: apb_rr_mst

Overview:
- Multi-requester APB master: shares one APB bus between NREQ internal requesters using round-robin arbitration.
- Runs the IDLE/SETUP/ACCESS protocol on behalf of the granted requester and returns read data and error status to it.
- Adds a wait-state timeout so a hung slave cannot lock the bus.
- Sits between system-side command sources (core, DMA, debug) and the peripheral APB fabric.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max ACCESS cycles without pready before abort (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  request pending per requester; held until its req_ack
- req_write  in  NREQ  1=write, 0=read, per requester
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- req_ack  out  NREQ  one-hot, 1-cycle pulse: request accepted
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: transfer complete
- rsp_rdata  out  DW  read data of the last completed transfer
- rsp_err  out  1  error flag of the last completed transfer (pslverr or timeout)
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- pready  in  1  slave ready
- prdata  in  DW  slave read data
- pslverr  in  1  slave error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - req_ack, rsp_valid, psel, penable, pwrite, rsp_err all 0.
  - paddr, pwdata, rsp_rdata all 0.
  - RR pointer last = NREQ-1, so requester 0 has top priority.
  - Timeout counter 0.
- Arbitration:
  - Winner is the first asserted req_valid searching last+1, last+2, ... modulo NREQ.
  - At the grant edge, last <= winner.
- IDLE: psel=0, penable=0. If any req_valid is high at a rising edge:
  - latch the winner index, req_write, req_addr and req_wdata into pwrite/paddr/pwdata;
  - next state SETUP;
  - req_ack[winner]=1 during the SETUP cycle only.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS; clear the timeout counter.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are stable throughout the transfer.
  - pready=0: stay in ACCESS and increment the counter. When the counter reaches TIMEOUT-1 with pready still 0, abort:
    - next cycle rsp_valid[g]=1, rsp_err=1, rsp_rdata=0;
    - state goes to IDLE (no back-to-back after a timeout).
  - pready=1: completion.
    - Next cycle rsp_valid[g]=1.
    - rsp_rdata = prdata if pwrite=0; rsp_rdata holds its previous value on writes.
    - rsp_err = pslverr.
    - If any req_valid is high in the pready cycle, arbitrate and go straight to SETUP (back-to-back, psel stays 1); otherwise go to IDLE.
- Simultaneous completion and back-to-back grant: rsp_valid for the old grantee and req_ack for the new one may assert in the same cycle.
- Requester contract:
  - A requester deasserts req_valid the cycle after its req_ack.
  - Its request fields are sampled only at the grant edge; later changes have no effect on the current transfer.
- Output hold: rsp_rdata and rsp_err hold until the next completion. paddr, pwdata and pwrite hold their last values in IDLE.
- rst asserted in any state, including mid-ACCESS: all registers return to reset values at that edge, and no rsp_valid is issued for the aborted transfer.
- Invariants: penable=1 implies psel=1. At most one bit of req_ack is high; at most one bit of rsp_valid is high.

Decomposition:
- apb_pkg holds:
  - state typedef: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10;
  - default AW/DW constants;
  - TIMEOUT default.
- Sub-module rr_arbiter(NREQ):
  - inputs: req vector and last pointer;
  - outputs: one-hot grant, encoded index, any_req;
  - purely combinational.
- The pointer register and the FSM stay in apb_rr_mst.

Test Plan:
- Single read, no wait states: req0 read addr 0x1000, prdata=0xDEADCAFE with pready=1 on the first ACCESS cycle -> psel high 2 cycles, req_ack[0] during SETUP, rsp_valid[0] one cycle later with rsp_rdata=0xDEADCAFE, rsp_err=0.
- All four requesters assert simultaneously, pready=1 always -> grants in order 0,1,2,3 back-to-back (psel held 8 cycles). Then req1 and req3 re-assert -> grant order 1,3.
- Wait states: write 0x12345678 to 0x20, pready delayed 3 cycles -> penable high 4 cycles, paddr and pwdata stable, rsp_valid with rsp_err=0.
- pslverr: read with pready=1, pslverr=1, prdata=0xAA -> rsp_err=1, rsp_rdata=0xAA.
- Timeout: TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid with rsp_err=1 and rsp_rdata=0, state IDLE.
- Reset mid-ACCESS: assert rst during a wait state -> next cycle all outputs 0, no rsp_valid. A new req2 after reset is granted before any higher index (pointer reset).
